// File: rtl/memlcd_pkg.sv
// Shared types and default timing for the colour memory-LCD frame sequencer.
package memlcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        GSP,
        BSP,
        DATA,
        GEN,
        TAIL
    } state_t;

    localparam int unsigned RGB_W         = 6;
    localparam int unsigned DEF_H_WORDS   = 88;
    localparam int unsigned DEF_V_LINES   = 176;
    localparam int unsigned DEF_CLK_DIV   = 50;
    localparam int unsigned DEF_GEN_TICKS = 2;

    // Counter width for a count that ranges over 0..n-1 (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/memlcd_tick_gen.sv
// Timing-tick prescaler: one tick every CLK_DIV enabled cycles.
module memlcd_tick_gen
    import memlcd_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick_c
);

    localparam int unsigned CW = cnt_w(CLK_DIV);

    logic [CW-1:0] count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            count <= '0;
        end else if (i_en) begin
            count <= (count == CW'(CLK_DIV - 1)) ? '0 : count + CW'(1);
        end
    end

    assign o_tick_c = i_en && (count == CW'(CLK_DIV - 1));

endmodule

// File: rtl/memlcd_frame_sequencer.sv
// One full panel refresh: drains the pixel FIFO and drives the memory-LCD timing pins.
module memlcd_frame_sequencer
    import memlcd_pkg::*;
#(
    parameter int unsigned H_WORDS   = DEF_H_WORDS,
    parameter int unsigned V_LINES   = DEF_V_LINES,
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter int unsigned GEN_TICKS = DEF_GEN_TICKS
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [RGB_W-1:0] i_fifo_data,
    input  logic             i_fifo_empty,
    output logic             o_fifo_rd,
    output logic             o_intb,
    output logic             o_gsp,
    output logic             o_gck,
    output logic             o_gen,
    output logic             o_bsp,
    output logic             o_bck,
    output logic [RGB_W-1:0] o_rgb,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic             o_underrun
);

    localparam int unsigned LW = cnt_w(V_LINES);
    localparam int unsigned WW = cnt_w(H_WORDS);
    localparam int unsigned GW = cnt_w(GEN_TICKS);

    state_t           state, state_d;
    logic [LW-1:0]    line, line_d;
    logic [WW-1:0]    word, word_d;
    logic [GW-1:0]    gen_cnt, gen_cnt_d;
    logic [RGB_W-1:0] rgb_d;
    logic             rd_d, intb_d, gsp_d, gck_d, gen_d, bsp_d, bck_d;
    logic             busy_d, done_d, underrun_d;
    logic             tick;

    memlcd_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_en     (state != IDLE),
        .i_clr    (state == IDLE),
        .o_tick_c (tick)
    );

    // State and registered pins.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            line         <= '0;
            word         <= '0;
            gen_cnt      <= '0;
            o_rgb        <= '0;
            o_fifo_rd    <= 1'b0;
            o_intb       <= 1'b0;
            o_gsp        <= 1'b0;
            o_gck        <= 1'b0;
            o_gen        <= 1'b0;
            o_bsp        <= 1'b0;
            o_bck        <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_underrun   <= 1'b0;
        end else begin
            state        <= state_d;
            line         <= line_d;
            word         <= word_d;
            gen_cnt      <= gen_cnt_d;
            o_rgb        <= rgb_d;
            o_fifo_rd    <= rd_d;
            o_intb       <= intb_d;
            o_gsp        <= gsp_d;
            o_gck        <= gck_d;
            o_gen        <= gen_d;
            o_bsp        <= bsp_d;
            o_bck        <= bck_d;
            o_busy       <= busy_d;
            o_frame_done <= done_d;
            o_underrun   <= underrun_d;
        end
    end

    // Next-state and next-pin logic; everything except start acceptance moves on a tick.
    always_comb begin
        state_d    = state;
        line_d     = line;
        word_d     = word;
        gen_cnt_d  = gen_cnt;
        rgb_d      = o_rgb;
        rd_d       = 1'b0;
        intb_d     = o_intb;
        gsp_d      = o_gsp;
        gck_d      = o_gck;
        gen_d      = o_gen;
        bsp_d      = o_bsp;
        bck_d      = o_bck;
        busy_d     = o_busy;
        done_d     = 1'b0;
        underrun_d = o_underrun;

        unique case (state)
            IDLE: begin
                if (i_start) begin
                    state_d    = SETUP;
                    busy_d     = 1'b1;
                    intb_d     = 1'b1;
                    underrun_d = 1'b0;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = GSP;
                    gsp_d   = 1'b1;
                end
            end
            GSP: begin
                if (tick) begin
                    gsp_d   = 1'b0;
                    gck_d   = ~o_gck;
                    line_d  = '0;
                    bsp_d   = 1'b1;
                    state_d = BSP;
                end
            end
            BSP: begin
                if (tick) begin
                    bsp_d   = 1'b0;
                    word_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (!i_fifo_empty) begin
                        rgb_d = i_fifo_data;
                        bck_d = ~o_bck;
                        rd_d  = 1'b1;
                        if (word == WW'(H_WORDS - 1)) begin
                            gen_d     = 1'b1;
                            gen_cnt_d = '0;
                            state_d   = GEN;
                        end else begin
                            word_d = word + WW'(1);
                        end
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
            end
            GEN: begin
                if (tick) begin
                    if (gen_cnt == GW'(GEN_TICKS - 1)) begin
                        gen_d = 1'b0;
                        gck_d = ~o_gck;
                        if (line == LW'(V_LINES - 1)) begin
                            state_d = TAIL;
                        end else begin
                            line_d  = line + LW'(1);
                            bsp_d   = 1'b1;
                            state_d = BSP;
                        end
                    end else begin
                        gen_cnt_d = gen_cnt + GW'(1);
                    end
                end
            end
            TAIL: begin
                if (tick) begin
                    intb_d  = 1'b0;
                    gck_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_memlcd_frame_sequencer.sv
// Self-checking bench for memlcd_frame_sequencer with a FIFO model and frame-level expectations.
module tb_memlcd_frame_sequencer;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int CD = 2;
    localparam int G  = 1;
    localparam int N  = H * V;
    localparam int BUDGET = 2000;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_start = 1'b0;
    logic [5:0] i_fifo_data = 6'd0;
    logic       i_fifo_empty = 1'b1;
    logic       o_fifo_rd, o_intb, o_gsp, o_gck, o_gen, o_bsp, o_bck;
    logic [5:0] o_rgb;
    logic       o_busy, o_frame_done, o_underrun;

    memlcd_frame_sequencer #(
        .H_WORDS   (H),
        .V_LINES   (V),
        .CLK_DIV   (CD),
        .GEN_TICKS (G)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_fifo_data  (i_fifo_data),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_rd    (o_fifo_rd),
        .o_intb       (o_intb),
        .o_gsp        (o_gsp),
        .o_gck        (o_gck),
        .o_gen        (o_gen),
        .o_bsp        (o_bsp),
        .o_bck        (o_bck),
        .o_rgb        (o_rgb),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_underrun   (o_underrun)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [5:0] fifo_q[$];
    logic [5:0] exp_q[$];

    int cyc, pops, toggles, line_tog, gsp_cyc, bsp_cnt, gck_edges, done_cnt;
    int err_order, err_overlap, err_intb, err_rd;
    int stall_w, stall_len, stall_hold;
    bit stall_used, force_empty;
    logic prev_bck, prev_gck, prev_gen, prev_bsp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        i_fifo_empty = force_empty || (fifo_q.size() == 0);
        i_fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 6'd0;
    endtask

    // One cycle: observe pins at the falling edge, update FIFO model and stall window.
    task automatic step();
        logic [31:0] exp_word;
        @(negedge clk);
        cyc++;
        if (o_fifo_rd) begin
            if (i_fifo_empty) err_rd++;
            if (o_bck == prev_bck) err_rd++;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            pops++;
        end
        if (o_bck != prev_bck) begin
            toggles++;
            line_tog++;
            exp_word = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD;
            chk("rgb_word", 32'(o_rgb), exp_word);
            if (!o_fifo_rd) err_rd++;
            if (prev_gen) err_overlap++;
            if (bsp_cnt != (toggles - 1) / H + 1) err_order++;
        end
        if (o_gen && !prev_gen) begin
            if (line_tog != H) err_order++;
            line_tog = 0;
        end
        if (o_gen && o_bsp) err_overlap++;
        if (o_gsp) gsp_cyc++;
        if (o_bsp && !prev_bsp) bsp_cnt++;
        if (o_gck != prev_gck && !o_frame_done) gck_edges++;
        if (o_intb !== o_busy) err_intb++;
        if (o_frame_done) done_cnt++;
        if (stall_hold > 0) begin
            stall_hold--;
            if (stall_hold == (stall_len - 1) * CD) chk("underrun_first_stall", 32'(o_underrun), 32'd1);
            if (stall_hold == 0) force_empty = 1'b0;
        end else if (stall_len > 0 && !stall_used && pops == stall_w) begin
            chk("underrun_before_stall", 32'(o_underrun), 32'd0);
            force_empty = 1'b1;
            stall_hold  = stall_len * CD;
            stall_used  = 1'b1;
        end
        drive_fifo();
        prev_bck = o_bck;
        prev_gck = o_gck;
        prev_gen = o_gen;
        prev_bsp = o_bsp;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pins"}, 32'({o_fifo_rd, o_intb, o_gsp, o_gck, o_gen, o_bsp, o_bck}), 32'd0);
        chk({tag, "_rgb"}, 32'(o_rgb), 32'd0);
        chk({tag, "_status"}, 32'({o_busy, o_frame_done, o_underrun}), 32'd0);
    endtask

    task automatic run_frame(input bit directed, input int sw, input int sl, input int mid, input bit abort);
        logic [5:0] d;
        int expc;
        bit aborted;
        aborted = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            d = directed ? 6'(i + 1) : 6'($urandom);
            fifo_q.push_back(d);
            exp_q.push_back(d);
        end
        stall_w = sw; stall_len = sl; stall_used = 1'b0; stall_hold = 0; force_empty = 1'b0;
        pops = 0; toggles = 0; line_tog = 0; gsp_cyc = 0; bsp_cnt = 0; gck_edges = 0; done_cnt = 0;
        err_order = 0; err_overlap = 0; err_intb = 0; err_rd = 0;
        expc = (3 + V * (1 + H + G) + sl) * CD;
        drive_fifo();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        cyc = 0;
        chk("accept_busy_intb", 32'({o_busy, o_intb}), 32'd3);
        chk("accept_underrun_clear", 32'(o_underrun), 32'd0);
        prev_bck = o_bck; prev_gck = o_gck; prev_gen = o_gen; prev_bsp = o_bsp;
        while (!o_frame_done && cyc < BUDGET) begin
            if (abort && toggles == H + 1) begin
                aborted = 1'b1;
                break;
            end
            step();
            i_start = (cyc == mid);
        end
        i_start = 1'b0;
        if (aborted) begin
            i_reset = 1'b1;
            @(negedge clk);
            chk_all_zero("abort");
            i_reset = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (o_fifo_rd || o_busy || o_bck) err_rd++;
            end
            chk("abort_quiet", 32'(err_rd), 32'd0);
            return;
        end
        chk("done_cycle", 32'(cyc), 32'(expc));
        chk("pops", 32'(pops), 32'(N));
        chk("bck_toggles", 32'(toggles), 32'(N));
        chk("gck_edges", 32'(gck_edges), 32'(V + 1));
        chk("gsp_cycles", 32'(gsp_cyc), 32'(CD));
        chk("bsp_pulses", 32'(bsp_cnt), 32'(V));
        chk("order_errs", 32'(err_order), 32'd0);
        chk("overlap_errs", 32'(err_overlap), 32'd0);
        chk("intb_span_errs", 32'(err_intb), 32'd0);
        chk("pop_errs", 32'(err_rd), 32'd0);
        chk("words_left", 32'(exp_q.size()), 32'd0);
        chk("end_pins", 32'({o_intb, o_gck, o_bck, o_busy}), 32'd0);
        chk("underrun_sticky", 32'(o_underrun), 32'(sl > 0));
        step();
        chk("done_one_cycle", 32'(o_frame_done), 32'd0);
        if (mid >= 0) begin
            for (int i = 0; i < 8; i++) step();
            chk("single_done", 32'(done_cnt), 32'd1);
            chk("no_restart", 32'(o_busy), 32'd0);
        end
    endtask

    initial begin
        int w, l;
        i_start = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_with_start");
        i_start = 1'b0;
        i_reset = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", 32'(o_busy), 32'd0);

        run_frame(1'b1, 0, 0, -1, 1'b0);
        run_frame(1'b1, 2, 3, -1, 1'b0);
        run_frame(1'b0, 0, 0, 11, 1'b0);
        for (int f = 0; f < 4; f++) begin
            w = $urandom_range(1, N - 1);
            if (w % H == 0) w--;
            l = $urandom_range(0, 4);
            run_frame(1'b0, w, l, -1, 1'b0);
        end
        run_frame(1'b0, 0, 0, -1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
